// File: rtl/fir_fold_ctrl_pkg.sv
// Shared constants, coefficient table, FSM states and circular-index helpers
// for the folded 21-tap symmetric FIR.
package fir_pkg;

    localparam int WORD_SIZE = 10;
    localparam int TAPS      = 21;
    localparam int NCOEF     = (TAPS + 1) / 2;
    localparam int ACC_W     = 21;
    localparam int OUT_W     = 12;

    localparam int COEF_W = 6;
    localparam int PRE_W  = WORD_SIZE + 1;
    localparam int PROD_W = PRE_W + COEF_W;
    localparam int PTR_W  = $clog2(TAPS);
    localparam int K_W    = $clog2(NCOEF);

    typedef logic signed [COEF_W-1:0] coef_t;
    typedef logic [PTR_W-1:0]         ptr_t;

    // Unique half of the symmetric impulse response; C[NCOEF-1] is the centre tap.
    localparam coef_t COEF [NCOEF] = '{
        -6'sd1, 6'sd1, 6'sd3, 6'sd2, -6'sd1, -6'sd4,
        -6'sd4, 6'sd1, 6'sd10, 6'sd18, 6'sd21
    };

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DONE
    } state_t;

    function automatic ptr_t tap_inc(input ptr_t p);
        return (p == ptr_t'(TAPS - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    // (p - j) mod TAPS for p, j already inside 0..TAPS-1.
    function automatic ptr_t tap_sub(input ptr_t p, input ptr_t j);
        logic [PTR_W:0] d;
        d = {1'b0, p} + (PTR_W+1)'(TAPS) - {1'b0, j};
        if (d >= (PTR_W+1)'(TAPS))
            d = d - (PTR_W+1)'(TAPS);
        return d[PTR_W-1:0];
    endfunction

endpackage

// File: rtl/fir_fold_ctrl_if.sv
// Sample-in / result-out handshake bundle for the folded FIR controller.
interface fir_fold_ctrl_if;
    import fir_pkg::*;

    logic signed [WORD_SIZE-1:0] in_data;
    logic                        in_valid;
    logic                        in_ready;
    logic signed [OUT_W-1:0]     out_data;
    logic                        out_valid;
    logic                        out_ready;
    logic                        busy;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, busy
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, busy
    );

endinterface

// File: rtl/fir_fold_ctrl_hist_buf.sv
// 21-entry circular sample history: one write port, two reads addressed
// relative to the newest sample (j = 0 is newest).
module fir_hist_buf
    import fir_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic signed [WORD_SIZE-1:0] din,
    input  ptr_t                        rd_j0,
    input  ptr_t                        rd_j1,
    output logic signed [WORD_SIZE-1:0] rd_x0,
    output logic signed [WORD_SIZE-1:0] rd_x1
);

    logic signed [WORD_SIZE-1:0] mem [TAPS];
    ptr_t                        wr_ptr;
    ptr_t                        wr_next;

    assign wr_next = tap_inc(wr_ptr);

    // The pointer moves first and the new sample lands at the moved position.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            for (int i = 0; i < TAPS; i++)
                mem[i] <= '0;
        end else if (push) begin
            wr_ptr       <= wr_next;
            mem[wr_next] <= din;
        end
    end

    assign rd_x0 = mem[tap_sub(wr_ptr, rd_j0)];
    assign rd_x1 = mem[tap_sub(wr_ptr, rd_j1)];

endmodule

// File: rtl/fir_fold_ctrl.sv
// Folded 21-tap symmetric FIR: one pre-adder and one MAC walk the 11
// coefficient pairs per sample, giving a 12-bit truncated result.
module fir_fold_ctrl
    import fir_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    fir_fold_ctrl_if.slave  bus
);

    state_t                      state;
    state_t                      state_n;
    logic [K_W-1:0]              k;
    logic signed [ACC_W-1:0]     acc;
    logic signed [ACC_W-1:0]     acc_next;
    logic signed [OUT_W-1:0]     out_data_q;
    logic                        out_valid_q;
    logic                        accept;
    logic                        last_k;
    ptr_t                        j_lo;
    ptr_t                        j_hi;
    logic signed [WORD_SIZE-1:0] x_lo;
    logic signed [WORD_SIZE-1:0] x_hi;
    logic signed [WORD_SIZE-1:0] x_hi_gated;
    logic signed [PRE_W-1:0]     pre;
    logic signed [PROD_W-1:0]    prod;
    coef_t                       coef;

    assign last_k = (k == K_W'(NCOEF - 1));
    assign j_lo   = ptr_t'(k);
    assign j_hi   = ptr_t'(TAPS - 1) - ptr_t'(k);

    fir_hist_buf u_hist (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .din   (bus.in_data),
        .rd_j0 (j_lo),
        .rd_j1 (j_hi),
        .rd_x0 (x_lo),
        .rd_x1 (x_hi)
    );

    // The centre tap has no mirror partner, so its second addend is zeroed.
    always_comb begin
        x_hi_gated = last_k ? '0 : x_hi;
        pre        = PRE_W'(x_lo) + PRE_W'(x_hi_gated);
        coef       = (int'(k) < NCOEF) ? COEF[k] : '0;
        prod       = PROD_W'(pre) * PROD_W'(coef);
        acc_next   = acc + ACC_W'(prod);
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    state_n = MAC;
                end
            end
            MAC: begin
                if (last_k)
                    state_n = DONE;
            end
            DONE: begin
                if (bus.out_ready)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Output keeps acc_next[11:1] with bit 0 cleared; higher bits simply wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            k           <= '0;
            acc         <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        k   <= '0;
                        acc <= '0;
                    end
                end
                MAC: begin
                    acc <= acc_next;
                    k   <= k + K_W'(1);
                    if (last_k) begin
                        out_data_q  <= {acc_next[OUT_W-1:1], 1'b0};
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready)
                        out_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_fir_fold_ctrl.sv
// Directed bench for fir_fold_ctrl, checked against hand-computed vectors and
// a direct-form 21-tap reference model.
module tb_fir_fold_ctrl;
    import fir_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fir_fold_ctrl_if bus ();

    fir_fold_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    always @(posedge clk) cyc++;

    localparam int H [21] = '{-1, 1, 3, 2, -1, -4, -4, 1, 10, 18, 21,
                              18, 10, 1, -4, -4, -1, 2, 3, 1, -1};
    localparam int IMP [22] = '{-50, 50, 150, 100, -50, -200, -200, 50, 500, 900, 1050,
                                900, 500, 50, -200, -200, -50, 100, 150, 50, -50, 0};

    int mh [21];

    task automatic model_clear();
        foreach (mh[i]) mh[i] = 0;
    endtask

    // Direct-form reference: newest sample in mh[0].
    task automatic model_push(input int v, output logic signed [11:0] e);
        int          acc;
        logic [31:0] a;
        for (int i = 20; i > 0; i--) mh[i] = mh[i-1];
        mh[0] = v;
        acc = 0;
        for (int i = 0; i < 21; i++) acc += mh[i] * H[i];
        a = acc;
        e = {a[11:1], 1'b0};
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic send(input int v, output bit ok);
        ok = 1'b0;
        bus.in_data  = 10'(v);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (bus.in_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    // Waits for a result (lat counts cycles since the accept cycle), then consumes it.
    task automatic recv(output logic signed [11:0] d, output int lat, output bit ok);
        ok  = 1'b0;
        lat = 1;
        d   = '0;
        while (!bus.out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (bus.out_valid) begin
            ok = 1'b1;
            d  = bus.out_data;
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (bus.in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset in_ready: got %b want 1", bus.in_ready);
        end
        tests_run++;
        if (bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset out_valid: got %b want 0", bus.out_valid);
        end
        tests_run++;
        if (bus.busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset busy: got %b want 0", bus.busy);
        end
        tests_run++;
        if (bus.out_data !== 12'sd0) begin
            tests_failed++;
            $display("[TB] FAIL reset out_data: got %0d want 0", bus.out_data);
        end
    endtask

    task automatic test_impulse(input string tag, input bit fresh);
        logic signed [11:0] d;
        int lat;
        bit ok;
        if (fresh) do_reset();
        bus.out_ready = 1'b1;
        for (int n = 0; n < 22; n++) begin
            send((n == 0) ? 50 : 0, ok);
            tests_run++;
            if (!ok) begin
                tests_failed++;
                $display("[TB] FAIL %s accept[%0d]: got timeout want accept", tag, n);
                continue;
            end
            recv(d, lat, ok);
            tests_run++;
            if (!ok || d !== 12'(IMP[n])) begin
                tests_failed++;
                $display("[TB] FAIL %s data[%0d]: got %0d (valid=%0d) want %0d", tag, n, d, ok, IMP[n]);
            end
            tests_run++;
            if (lat != 12) begin
                tests_failed++;
                $display("[TB] FAIL %s latency[%0d]: got %0d want 12", tag, n, lat);
            end
        end
    endtask

    task automatic test_step();
        logic signed [11:0] d, e;
        int lat, t, prev;
        bit ok;
        do_reset();
        bus.out_ready = 1'b1;
        prev = 0;
        for (int n = 0; n < 30; n++) begin
            send(10, ok);
            t = cyc;
            model_push(10, e);
            if (n > 0) begin
                tests_run++;
                if (t - prev != 13) begin
                    tests_failed++;
                    $display("[TB] FAIL step period[%0d]: got %0d want 13", n, t - prev);
                end
            end
            prev = t;
            recv(d, lat, ok);
            tests_run++;
            if (!ok || d !== e) begin
                tests_failed++;
                $display("[TB] FAIL step data[%0d]: got %0d want %0d", n, d, e);
            end
            if (n >= 20) begin
                tests_run++;
                if (d !== 12'sd710) begin
                    tests_failed++;
                    $display("[TB] FAIL step steady[%0d]: got %0d want 710", n, d);
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic signed [11:0] d, e;
        int lat;
        bit ok;
        do_reset();
        bus.out_ready = 1'b1;
        for (int n = 0; n < 30; n++) begin
            send(-512, ok);
            model_push(-512, e);
            recv(d, lat, ok);
            tests_run++;
            if (!ok || d !== e) begin
                tests_failed++;
                $display("[TB] FAIL wrap data[%0d]: got %0d want %0d", n, d, e);
            end
        end
        tests_run++;
        if (d !== 12'sd512) begin
            tests_failed++;
            $display("[TB] FAIL wrap steady: got %0d want 512", d);
        end
    endtask

    task automatic test_backpressure();
        logic signed [11:0] d, e, e2;
        int lat, waited;
        bit ok;
        do_reset();
        bus.out_ready = 1'b0;
        send(100, ok);
        model_push(100, e);
        waited = 0;
        while (!bus.out_valid && waited < 60) begin
            @(posedge clk);
            #1;
            waited++;
        end
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== e) begin
            tests_failed++;
            $display("[TB] FAIL bp first result: got valid=%b data=%0d want valid=1 data=%0d",
                     bus.out_valid, bus.out_data, e);
        end
        bus.in_data  = 10'sd7;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            tests_run++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== e) begin
                tests_failed++;
                $display("[TB] FAIL bp hold[%0d]: got valid=%b data=%0d want valid=1 data=%0d",
                         c, bus.out_valid, bus.out_data, e);
            end
            tests_run++;
            if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL bp stall[%0d]: got in_ready=%b busy=%b want in_ready=0 busy=1",
                         c, bus.in_ready, bus.busy);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL bp release: got valid=%b in_ready=%b busy=%b want 0 1 0",
                     bus.out_valid, bus.in_ready, bus.busy);
        end
        send(0, ok);
        model_push(0, e2);
        recv(d, lat, ok);
        tests_run++;
        if (!ok || d !== e2) begin
            tests_failed++;
            $display("[TB] FAIL bp no_accept: got %0d want %0d", d, e2);
        end
    endtask

    task automatic test_reset_mid_mac();
        logic signed [11:0] d;
        int lat;
        bit ok;
        do_reset();
        bus.out_ready = 1'b1;
        send(50, ok);
        recv(d, lat, ok);
        send(30, ok);
        // Now in the cycle with k = 0; five more edges bring k to 5.
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tests_run++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL midreset state: got busy=%b valid=%b in_ready=%b want 0 0 1",
                     bus.busy, bus.out_valid, bus.in_ready);
        end
        tests_run++;
        if (bus.out_data !== 12'sd0) begin
            tests_failed++;
            $display("[TB] FAIL midreset out_data: got %0d want 0", bus.out_data);
        end
        model_clear();
        test_impulse("post_reset_impulse", 1'b0);
    endtask

    task automatic test_random();
        logic signed [11:0] e, exp_q[$];
        int  sent, got, cycles;
        bit  in_fire, out_fire;
        do_reset();
        sent = 0;
        got = 0;
        cycles = 0;
        while (got < 200 && cycles < 20000) begin
            if (!bus.in_valid && sent < 200 && $urandom_range(0, 1) == 1) begin
                bus.in_valid = 1'b1;
                bus.in_data  = 10'($urandom_range(0, 1023));
            end
            bus.out_ready = ($urandom_range(0, 2) != 0);
            in_fire  = bus.in_valid && bus.in_ready;
            out_fire = bus.out_valid && bus.out_ready;
            if (out_fire) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL random extra result: got %0d want none", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.out_data !== e) begin
                        tests_failed++;
                        $display("[TB] FAIL random data[%0d]: got %0d want %0d", got, bus.out_data, e);
                    end
                end
                got++;
            end
            if (in_fire) begin
                model_push(int'(bus.in_data), e);
                exp_q.push_back(e);
            end
            @(posedge clk);
            #1;
            if (in_fire) begin
                bus.in_valid = 1'b0;
                sent++;
            end
            cycles++;
        end
        bus.in_valid = 1'b0;
        tests_run++;
        if (got != 200 || exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL random count: got %0d results (%0d pending) want 200 (0 pending)",
                     got, exp_q.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_impulse("impulse", 1'b1);
        test_step();
        test_wrap();
        test_backpressure();
        test_reset_mid_mac();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
